// File: rtl/gin_mcast.sv
// gin_mcast: FIFO-fed multicast input network delivering tagged packets atomically to every matching PE
module gin_mcast #(
  parameter int BITWIDTH   = 16,
  parameter int TAG_LENGTH = 4,
  parameter int X_BUS_SIZE = 4,
  parameter int Y_BUS_SIZE = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     i_program,
  input  logic [TAG_LENGTH-1:0]                    i_scan_tag_in,
  output logic [TAG_LENGTH-1:0]                    o_scan_tag_out,
  input  logic                                     i_gin_enable,
  output logic                                     o_gin_ready,
  input  logic [2*TAG_LENGTH+BITWIDTH-1:0]         i_data_packet,
  output logic [X_BUS_SIZE*Y_BUS_SIZE-1:0]         o_pe_enable,
  input  logic [X_BUS_SIZE*Y_BUS_SIZE-1:0]         i_pe_ready,
  output logic [BITWIDTH*X_BUS_SIZE*Y_BUS_SIZE-1:0] o_pe_value,
  output logic [$clog2(FIFO_DEPTH):0]              o_fifo_count,
  output logic [CNT_WIDTH-1:0]                     o_drop_count
);
  localparam int NPE = X_BUS_SIZE * Y_BUS_SIZE;
  localparam int N   = Y_BUS_SIZE + NPE;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int PW  = 2 * TAG_LENGTH + BITWIDTH;
  typedef enum logic [1:0] {IDLE, ISSUE, PROG} state_t;
  state_t                  r_state, w_state_nxt;
  logic [TAG_LENGTH-1:0]   r_scan [N];
  logic [PW-1:0]           r_mem [FIFO_DEPTH];
  logic [AW-1:0]           r_wp, r_rp;
  logic [CW-1:0]           r_cnt, w_cnt_nxt;
  logic [CNT_WIDTH-1:0]    r_drop;
  logic [NPE-1:0]          r_en, w_mask;
  logic [BITWIDTH*NPE-1:0] r_val;
  logic [PW-1:0]           w_head;
  logic [TAG_LENGTH-1:0]   w_row, w_col;
  logic [BITWIDTH-1:0]     w_data;
  logic                    w_push, w_pop, w_drop, w_deliver, w_issue;
  assign w_head = r_mem[r_rp];
  assign w_row = w_head[PW-1 -: TAG_LENGTH];
  assign w_col = w_head[BITWIDTH +: TAG_LENGTH];
  assign w_data = w_head[BITWIDTH-1:0];
  assign o_gin_ready = (r_cnt != CW'(FIFO_DEPTH)) && !i_program;
  assign w_push = i_gin_enable && o_gin_ready;
  assign o_scan_tag_out = r_scan[N-1];
  assign o_fifo_count = r_cnt;
  assign o_drop_count = r_drop;
  assign o_pe_enable = r_en;
  assign o_pe_value = r_val;
  genvar i;
  for (i = 0; i < NPE; i++) begin : g_m
    assign w_mask[i] = (w_row == r_scan[N-1-i/X_BUS_SIZE] || &w_row) && (w_col == r_scan[N-1-Y_BUS_SIZE-i] || &w_col);
  end
  always_comb begin
    w_issue = (r_state == ISSUE) && (r_cnt != '0);
    w_drop = w_issue && (w_mask == '0);
    w_deliver = w_issue && (w_mask != '0) && ((i_pe_ready & w_mask) == w_mask);
    w_pop = w_drop || w_deliver;
    w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);
    w_state_nxt = i_program ? PROG : (r_state == PROG) ? IDLE : (w_cnt_nxt != '0) ? ISSUE : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
      r_drop <= '0;
      r_en <= '0;
      r_val <= '0;
      for (int k = 0; k < N; k++) r_scan[k] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      if (w_drop && !(&r_drop)) r_drop <= r_drop + CNT_WIDTH'(1);
      r_en <= w_deliver ? w_mask : '0;
      for (int k = 0; k < NPE; k++)
        if (w_deliver && w_mask[k]) r_val[BITWIDTH*k +: BITWIDTH] <= w_data;
      if (i_program) begin
        r_scan[0] <= i_scan_tag_in;
        for (int k = 1; k < N; k++) r_scan[k] <= r_scan[k-1];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_data_packet;
  end
endmodule

// File: tb/tb_gin_mcast.sv
// tb_gin_mcast: directed self-checking bench for gin_mcast
module tb_gin_mcast;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          prog = 1'b0;
  logic [3:0]    scan_in = '0;
  logic [3:0]    scan_out;
  logic          gin_en = 1'b0;
  logic          gin_rdy;
  logic [23:0]   pkt = '0;
  logic [15:0]   pe_en;
  logic [15:0]   pe_rdy = '1;
  logic [255:0]  pe_val;
  logic [2:0]    fcnt;
  logic [7:0]    dcnt;
  logic [255:0]  exp_val = '0;
  int            total = 0;
  int            bad = 0;
  int            words [20] = '{0,1,2,3, 0,1,2,3, 1,2,3,4, 2,3,4,5, 3,4,5,6};
  gin_mcast dut (
    .clk(clk), .rst(rst), .i_program(prog), .i_scan_tag_in(scan_in), .o_scan_tag_out(scan_out),
    .i_gin_enable(gin_en), .o_gin_ready(gin_rdy), .i_data_packet(pkt), .o_pe_enable(pe_en),
    .i_pe_ready(pe_rdy), .o_pe_value(pe_val), .o_fifo_count(fcnt), .o_drop_count(dcnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic send_one(input string tag, input logic [23:0] p, input logic [15:0] mask);
    pkt = p;
    gin_en = 1'b1;
    step;
    gin_en = 1'b0;
    chk({tag, "_lat"}, 256'(pe_en), 256'(0));
    step;
    for (int k = 0; k < 16; k++) if (mask[k]) exp_val[16*k +: 16] = p[15:0];
    chk({tag, "_en"}, 256'(pe_en), 256'(mask));
    chk({tag, "_val"}, pe_val, exp_val);
    step;
    chk({tag, "_pulse"}, 256'(pe_en), 256'(0));
  endtask
  initial begin
    step;
    step;
    rst = 1'b0;
    chk("rst_cnt", 256'(fcnt), 256'(0));
    chk("rst_drop", 256'(dcnt), 256'(0));
    chk("rst_en", 256'(pe_en), 256'(0));
    chk("rst_val", pe_val, 256'(0));
    chk("rst_rdy", 256'(gin_rdy), 256'(1));
    prog = 1'b1;
    #1;
    chk("prog_rdy", 256'(gin_rdy), 256'(0));
    for (int k = 0; k < 20; k++) begin
      scan_in = 4'(words[k]);
      step;
    end
    prog = 1'b0;
    step;
    chk("scan_out", 256'(scan_out), 256'(0));
    send_one("pe6", {4'h1, 4'h3, 16'h00AA}, 16'h0040);
    send_one("diag", {4'hF, 4'h3, 16'hBEEF}, 16'h1248);
    send_one("pe15", {4'h3, 4'h6, 16'h1234}, 16'h8000);
    send_one("row2", {4'h2, 4'hF, 16'h5A5A}, 16'h0F00);
    pe_rdy = 16'hFFBF;
    gin_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      pkt = {4'h1, 4'h3, 16'(16'h0100 + k)};
      step;
    end
    pkt = {4'h1, 4'h3, 16'h0105};
    chk("stall_cnt", 256'(fcnt), 256'(4));
    chk("stall_rdy", 256'(gin_rdy), 256'(0));
    chk("stall_en", 256'(pe_en), 256'(0));
    pe_rdy = '1;
    for (int j = 1; j <= 5; j++) begin
      step;
      if (j == 2) gin_en = 1'b0;
      exp_val[16*6 +: 16] = 16'(16'h0100 + j);
      chk("drain_en", 256'(pe_en), 256'(16'h0040));
      chk("drain_val", pe_val, exp_val);
    end
    chk("drain_cnt", 256'(fcnt), 256'(0));
    pkt = {4'h7, 4'h7, 16'hDEAD};
    gin_en = 1'b1;
    step;
    gin_en = 1'b0;
    step;
    chk("drop1_cnt", 256'(dcnt), 256'(1));
    chk("drop1_en", 256'(pe_en), 256'(0));
    chk("drop1_val", pe_val, exp_val);
    gin_en = 1'b1;
    repeat (300) step;
    gin_en = 1'b0;
    repeat (3) step;
    chk("drop_sat", 256'(dcnt), 256'(255));
    chk("drop_fifo", 256'(fcnt), 256'(0));
    pe_rdy = 16'hFFBF;
    pkt = {4'h1, 4'h3, 16'h0200};
    gin_en = 1'b1;
    step;
    step;
    gin_en = 1'b0;
    chk("q2_cnt", 256'(fcnt), 256'(2));
    prog = 1'b1;
    #1;
    chk("q2_rdy", 256'(gin_rdy), 256'(0));
    step;
    pe_rdy = '1;
    for (int k = 0; k < 3; k++) begin
      step;
      chk("prog_hold_en", 256'(pe_en), 256'(0));
    end
    chk("prog_hold_cnt", 256'(fcnt), 256'(2));
    rst = 1'b1;
    step;
    chk("mid_rst_cnt", 256'(fcnt), 256'(0));
    chk("mid_rst_en", 256'(pe_en), 256'(0));
    chk("mid_rst_val", pe_val, 256'(0));
    rst = 1'b0;
    prog = 1'b0;
    step;
    chk("post_rst_rdy", 256'(gin_rdy), 256'(1));
    chk("post_rst_drop", 256'(dcnt), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gin_mcast.md
# gin_mcast

Parametrised global input network for the PE array. Packets of the form {row_tag, col_tag, data} enter through an input FIFO, then multicast to every PE whose scan-programmed row ID and column ID match the packet tags. An all-ones tag is a wildcard, so one packet can reach a whole row, column, diagonal or the full array. Delivery is atomic: a packet issues only when every target PE is ready. Packets with no target are dropped and counted. The block sits between the global buffer and the PE array, in the place of the single-entry GIN.

## Interface
- BITWIDTH, 16, data payload width
- TAG_LENGTH, 4, width of row/col tags and IDs; all-ones = wildcard
- X_BUS_SIZE, 4, PEs per row (columns)
- Y_BUS_SIZE, 4, rows
- FIFO_DEPTH, 4, input FIFO entries (power of two, ≥2)
- CNT_WIDTH, 8, drop counter width

- clk  in  1  clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- program  in  1  scan-chain shift enable
- scan_tag_in  in  TAG_LENGTH  scan data in
- scan_tag_out  out  TAG_LENGTH  last scan stage
- gin_enable  in  1  input packet valid
- gin_ready  out  1  FIFO can accept
- data_packet  in  2*TAG_LENGTH+BITWIDTH  {row_tag, col_tag, data}, MSB first
- pe_enable  out  X_BUS_SIZE*Y_BUS_SIZE  one-cycle delivery strobe per PE
- pe_ready  in  X_BUS_SIZE*Y_BUS_SIZE  PE can accept
- pe_value  out  BITWIDTH*X_BUS_SIZE*Y_BUS_SIZE  per-PE data
- fifo_count  out  clog2(FIFO_DEPTH)+1  entries held
- drop_count  out  CNT_WIDTH  saturating count of untargeted packets

## Operation
- PE index i = r*X_BUS_SIZE + c. Bit i of pe_enable/pe_ready and slice [BITWIDTH*i +: BITWIDTH] of pe_value belong to PE (r,c).
- Scan chain: N = Y + X*Y stages, each TAG_LENGTH wide.
  - On each program=1 cycle: stage0 ← scan_tag_in and stage k ← stage k-1.
  - scan_tag_out = stage N-1.
  - After N shifts, the first word is the row ID of row 0, followed by rows 1..Y-1. The words after that are the col IDs of PE (0,0),(0,1),…,(Y-1,X-1) in that order.
- Match: PE (r,c) is targeted when both hold:
  - row_tag == rowID[r] or row_tag is all-ones
  - col_tag == colID[r][c] or col_tag is all-ones
- target_mask is computed combinationally from the FIFO head.
- FSM states:
  - PROG: entered while program=1, from any state. gin_ready=0, no issue, FIFO contents retained. Returns to IDLE when program=0.
  - IDLE: FIFO empty. Goes to ISSUE when fifo_count>0.
  - ISSUE: evaluates the head every cycle.
    - target_mask==0: pop the head and increment drop_count (saturating at all-ones).
    - (pe_ready & target_mask)==target_mask: register pe_enable←target_mask, load data into the targeted pe_value slices (others hold), pop the head.
    - Otherwise stall; the head and outputs hold, pe_enable=0.
    - Goes to IDLE when the pop empties the FIFO and no push occurs.
- gin_ready = !full && !program. A push when full is refused even if a pop occurs the same cycle.
- Push and pop in the same cycle leave fifo_count unchanged. FIFO pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset (rst=1 at a clk edge):
  - Clears all scan stages to 0, FIFO pointers, fifo_count, drop_count, pe_enable and pe_value to 0.
  - State → IDLE. gin_ready=1 while rst=0 follows.
  - Mid-operation reset discards FIFO contents and an in-flight strobe the next cycle.
- Latency: a packet accepted at edge N (gin_enable & gin_ready) is at the head after N. If its targets are ready, pe_enable and pe_value are valid after edge N+1 (2 cycles from presentation).
- Throughput: 1 packet/cycle while targets stay ready.
- pe_enable is a single-cycle pulse per delivered packet. Back-to-back deliveries give consecutive pulses.
- Dropped packets consume one ISSUE cycle and produce no strobe.
- A program edge mid-stall freezes delivery from the next cycle. Delivery resumes with the same head, re-matched against the new IDs.
- gin_ready and fifo_count are registered-state functions. No combinational path runs from pe_ready to gin_ready.

## Test plan
- Reset then scan 20 words: 0,1,2,3, then 0,1,2,3, 1,2,3,4, 2,3,4,5, 3,4,5,6. Then scan_tag_out shows the first word (0), row IDs are 0..3, and colID[3][3]=6.
- With that program, all pe_ready=1, send {1,3,0x00AA}. pe_enable=0x0040 (PE 6) two cycles after presentation, pe_value slice 6=0x00AA, other slices 0.
- Send {0xF,3,0xBEEF}. pe_enable=0x1248 (PEs 3,6,9,12), and those slices = 0xBEEF.
- Hold pe_ready[6]=0, send {1,3,x}, then 4 more packets. No strobe, and gin_ready falls once fifo_count=4. Raise pe_ready[6]: strobes issue on consecutive cycles, fifo_count drains to 0.
- Send {7,7,x}: no strobe, and drop_count increments by 1. Send 300 such packets: drop_count saturates at 255.
- Assert program while 2 packets are queued: gin_ready=0 and no issue during PROG. Pulse rst mid-queue: fifo_count=0 and pe_enable=0 the next cycle.
